id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS core, combined with load-use hazard detection.
- Captures decoded operands and control from ID. Drives the EX-stage register addresses and controls that the EX-stage forwarding logic compares against MEM/WB destinations.
- Generates the IF/ID/PC stall on a load-use hazard and inserts a bubble into EX.
- Honours a global freeze and a branch flush.

---
 rtl/id_ex_stage.sv | 119 +++++++++++
 tb/tb_id_ex_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard stall. One-cycle latency; optional HAZARD_STATS_EN adds event counters.
// Backpressure: Stall_ID (combinational) holds PC/IF-ID for one cycle on a load-use hazard; hold_i freezes all state.
module id_ex_stage #(
   parameter int DATA_W  = 32,
   parameter int ALUOP_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               hold_i,
   input  logic               flush_i,
   input  logic               Valid_ID,
   input  logic [4:0]         RsAddr_ID,
   input  logic [4:0]         RtAddr_ID,
   input  logic [4:0]         RdAddr_ID,
   input  logic               UsesRt_ID,
   input  logic               RegWrite_ID,
   input  logic               MemRead_ID,
   input  logic               MemWrite_ID,
   input  logic               MemtoReg_ID,
   input  logic               ALUSrc_ID,
   input  logic [ALUOP_W-1:0] ALUOp_ID,
   input  logic [DATA_W-1:0]  RsData_ID,
   input  logic [DATA_W-1:0]  RtData_ID,
   input  logic [DATA_W-1:0]  Imm_ID,
   output logic               Valid_EX,
   output logic [4:0]         RsAddr_EX,
   output logic [4:0]         RtAddr_EX,
   output logic [4:0]         RdAddr_EX,
   output logic               RegWrite_EX,
   output logic               MemRead_EX,
   output logic               MemWrite_EX,
   output logic               MemtoReg_EX,
   output logic               ALUSrc_EX,
   output logic [ALUOP_W-1:0] ALUOp_EX,
   output logic [DATA_W-1:0]  RsData_EX,
   output logic [DATA_W-1:0]  RtData_EX,
   output logic [DATA_W-1:0]  Imm_EX,
   output logic               Stall_ID
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]        StallCnt,
   output logic [31:0]        FlushCnt,
   output logic [31:0]        HoldCnt
`endif
);

   logic srcMatch;
   logic hazard;
   logic loadBubble;

   assign srcMatch   = (RdAddr_EX == RsAddr_ID) | (UsesRt_ID & (RdAddr_EX == RtAddr_ID));
   assign hazard     = Valid_EX & MemRead_EX & (RdAddr_EX != 5'd0) & Valid_ID & srcMatch;
   assign Stall_ID   = hazard & ~hold_i & ~flush_i;
   assign loadBubble = flush_i | hazard;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Valid_EX    <= 1'b0;
         RsAddr_EX   <= '0;
         RtAddr_EX   <= '0;
         RdAddr_EX   <= '0;
         RegWrite_EX <= 1'b0;
         MemRead_EX  <= 1'b0;
         MemWrite_EX <= 1'b0;
         MemtoReg_EX <= 1'b0;
         ALUSrc_EX   <= 1'b0;
         ALUOp_EX    <= '0;
         RsData_EX   <= '0;
         RtData_EX   <= '0;
         Imm_EX      <= '0;
      end else if (!hold_i) begin
         if (loadBubble) begin
            // Zero addresses keep the EX forwarding comparators from matching a bubble.
            Valid_EX    <= 1'b0;
            RsAddr_EX   <= '0;
            RtAddr_EX   <= '0;
            RdAddr_EX   <= '0;
            RegWrite_EX <= 1'b0;
            MemRead_EX  <= 1'b0;
            MemWrite_EX <= 1'b0;
            MemtoReg_EX <= 1'b0;
            ALUSrc_EX   <= 1'b0;
            ALUOp_EX    <= '0;
            RsData_EX   <= '0;
            RtData_EX   <= '0;
            Imm_EX      <= '0;
         end else begin
            Valid_EX    <= Valid_ID;
            RsAddr_EX   <= RsAddr_ID;
            RtAddr_EX   <= RtAddr_ID;
            RdAddr_EX   <= RdAddr_ID;
            RegWrite_EX <= RegWrite_ID & Valid_ID;
            MemRead_EX  <= MemRead_ID  & Valid_ID;
            MemWrite_EX <= MemWrite_ID & Valid_ID;
            MemtoReg_EX <= MemtoReg_ID & Valid_ID;
            ALUSrc_EX   <= ALUSrc_ID   & Valid_ID;
            ALUOp_EX    <= ALUOp_ID;
            RsData_EX   <= RsData_ID;
            RtData_EX   <= RtData_ID;
            Imm_EX      <= Imm_ID;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         StallCnt <= '0;
         FlushCnt <= '0;
         HoldCnt  <= '0;
      end else begin
         if (Stall_ID)           StallCnt <= StallCnt + 32'd1;
         if (flush_i && !hold_i) FlushCnt <= FlushCnt + 32'd1;
         if (hold_i)             HoldCnt  <= HoldCnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against a transaction-level model of the EX slot.
module tb_id_ex_stage;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic        regWrite;
      logic        memRead;
      logic        memWrite;
      logic        memtoReg;
      logic        aluSrc;
      logic [3:0]  aluOp;
      logic [31:0] rsData;
      logic [31:0] rtData;
      logic [31:0] imm;
   } ex_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic hold = 1'b0;
   logic flush = 1'b0;
   logic usesRt = 1'b0;
   ex_t  inp = '0;
   ex_t  mdl;
   ex_t  dutEx;
   logic chkOn = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   int   mStall = 0, mFlush = 0, mHold = 0;

   logic        Valid_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, ALUSrc_EX, Stall_ID;
   logic [4:0]  RsAddr_EX, RtAddr_EX, RdAddr_EX;
   logic [3:0]  ALUOp_EX;
   logic [31:0] RsData_EX, RtData_EX, Imm_EX;
`ifdef HAZARD_STATS_EN
   logic [31:0] StallCnt, FlushCnt, HoldCnt;
`endif

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(32), .ALUOP_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .hold_i(hold), .flush_i(flush),
      .Valid_ID(inp.valid), .RsAddr_ID(inp.rs), .RtAddr_ID(inp.rt), .RdAddr_ID(inp.rd),
      .UsesRt_ID(usesRt), .RegWrite_ID(inp.regWrite), .MemRead_ID(inp.memRead),
      .MemWrite_ID(inp.memWrite), .MemtoReg_ID(inp.memtoReg), .ALUSrc_ID(inp.aluSrc),
      .ALUOp_ID(inp.aluOp), .RsData_ID(inp.rsData), .RtData_ID(inp.rtData), .Imm_ID(inp.imm),
      .Valid_EX(Valid_EX), .RsAddr_EX(RsAddr_EX), .RtAddr_EX(RtAddr_EX), .RdAddr_EX(RdAddr_EX),
      .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
      .MemtoReg_EX(MemtoReg_EX), .ALUSrc_EX(ALUSrc_EX), .ALUOp_EX(ALUOp_EX),
      .RsData_EX(RsData_EX), .RtData_EX(RtData_EX), .Imm_EX(Imm_EX), .Stall_ID(Stall_ID)
`ifdef HAZARD_STATS_EN
      , .StallCnt(StallCnt), .FlushCnt(FlushCnt), .HoldCnt(HoldCnt)
`endif
   );

   assign dutEx = {Valid_EX, RsAddr_EX, RtAddr_EX, RdAddr_EX, RegWrite_EX, MemRead_EX,
                   MemWrite_EX, MemtoReg_EX, ALUSrc_EX, ALUOp_EX, RsData_EX, RtData_EX, Imm_EX};

   // A load in EX blocks an ID instruction that reads its destination (r0 excluded).
   function automatic logic loadUse(ex_t ex, ex_t id, logic ur);
      return ex.valid && ex.memRead && ex.rd != 0 && id.valid &&
             (ex.rd == id.rs || (ur && ex.rd == id.rt));
   endfunction

   function automatic ex_t nextEx(ex_t cur, ex_t id, logic ur, logic h, logic f);
      ex_t n;
      if (h) return cur;
      if (f || loadUse(cur, id, ur)) return '0;
      n = id;
      if (!id.valid) begin
         n.regWrite = 0; n.memRead = 0; n.memWrite = 0; n.memtoReg = 0; n.aluSrc = 0;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdl = '0; mStall = 0; mFlush = 0; mHold = 0;
      end else begin
         if (!hold && !flush && loadUse(mdl, inp, usesRt)) mStall++;
         if (flush && !hold) mFlush++;
         if (hold) mHold++;
         mdl = nextEx(mdl, inp, usesRt, hold, flush);
      end
   end

   always @(negedge clk) begin
      if (chkOn) begin
         vectors++;
         if (dutEx !== mdl) begin
            miscompares++;
            $display("FAIL exRegs dut=%h model=%h", dutEx, mdl);
         end
         vectors++;
         if (Stall_ID !== (loadUse(mdl, inp, usesRt) && !hold && !flush)) begin
            miscompares++;
            $display("FAIL stall dut=%b model=%b", Stall_ID, loadUse(mdl, inp, usesRt) && !hold && !flush);
         end
`ifdef HAZARD_STATS_EN
         vectors++;
         if (StallCnt !== mStall || FlushCnt !== mFlush || HoldCnt !== mHold) begin
            miscompares++;
            $display("FAIL counters dut=%0d/%0d/%0d model=%0d/%0d/%0d",
                     StallCnt, FlushCnt, HoldCnt, mStall, mFlush, mHold);
         end
`endif
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   function automatic ex_t mkInstr(logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                   logic rw, logic mr);
      ex_t e;
      e = '0;
      e.valid = v; e.rs = rs; e.rt = rt; e.rd = rd; e.regWrite = rw; e.memRead = mr;
      e.memtoReg = mr; e.aluSrc = mr; e.aluOp = 4'h2;
      e.rsData = 32'hA5A5_0000 | rs; e.rtData = 32'h5A5A_0000 | rt; e.imm = 32'h10;
      return e;
   endfunction

   logic [31:0] b0, b1;

   initial begin
      #3;
      chk("reset_valid", {31'd0, Valid_EX}, 32'd0);
      chk("reset_stall", {31'd0, Stall_ID}, 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      chkOn = 1'b1;

      // lw r8 followed by dependent add: one bubble, then the add.
      inp = mkInstr(1, 5'd9, 5'd8, 5'd8, 1, 1);
      cyc();
      chk("lw_valid", {31'd0, Valid_EX}, 32'd1);
      chk("lw_rd", {27'd0, RdAddr_EX}, 32'd8);
      inp = mkInstr(1, 5'd8, 5'd3, 5'd10, 1, 0); usesRt = 1;
      #1 chk("lu_stall", {31'd0, Stall_ID}, 32'd1);
      cyc();
      chk("bub_valid", {31'd0, Valid_EX}, 32'd0);
      chk("bub_regw", {31'd0, RegWrite_EX}, 32'd0);
      chk("bub_rd", {27'd0, RdAddr_EX}, 32'd0);
      chk("bub_stall", {31'd0, Stall_ID}, 32'd0);
      cyc();
      chk("add_rs", {27'd0, RsAddr_EX}, 32'd8);
      chk("add_valid", {31'd0, Valid_EX}, 32'd1);

      // ori names r8 in Rt but does not read it.
      inp = mkInstr(1, 5'd9, 5'd8, 5'd8, 1, 1); usesRt = 1;
      cyc();
      inp = mkInstr(1, 5'd1, 5'd8, 5'd8, 1, 0); usesRt = 0;
      #1 chk("ori_stall", {31'd0, Stall_ID}, 32'd0);
      cyc();
      chk("ori_rt", {27'd0, RtAddr_EX}, 32'd8);
      chk("ori_valid", {31'd0, Valid_EX}, 32'd1);

      // Flush wins over the hazard.
      inp = mkInstr(1, 5'd9, 5'd8, 5'd8, 1, 1);
      cyc();
      inp = mkInstr(1, 5'd8, 5'd2, 5'd11, 1, 0); flush = 1;
      #1 chk("flush_stall", {31'd0, Stall_ID}, 32'd0);
`ifdef HAZARD_STATS_EN
      b0 = FlushCnt; b1 = StallCnt;
`endif
      cyc();
      flush = 0;
      chk("flush_valid", {31'd0, Valid_EX}, 32'd0);
      chk("flush_rd", {27'd0, RdAddr_EX}, 32'd0);
`ifdef HAZARD_STATS_EN
      chk("flush_cnt", FlushCnt - b0, 32'd1);
      chk("flush_stallcnt", StallCnt - b1, 32'd0);
`endif

      // Three-cycle hold with a pending hazard that must not act.
      inp = mkInstr(1, 5'd4, 5'd6, 5'd5, 1, 1); inp.rsData = 32'h1234;
      cyc();
      hold = 1; inp = mkInstr(1, 5'd5, 5'd0, 5'd12, 1, 0);
#1    chk("hold_stall0", {31'd0, Stall_ID}, 32'd0);
`ifdef HAZARD_STATS_EN
      b0 = HoldCnt;
`endif
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("hold_rd", {27'd0, RdAddr_EX}, 32'd5);
         chk("hold_rsdata", RsData_EX, 32'h1234);
         chk("hold_stall", {31'd0, Stall_ID}, 32'd0);
      end
`ifdef HAZARD_STATS_EN
      chk("hold_cnt", HoldCnt - b0, 32'd3);
`endif
      hold = 0;
      inp = mkInstr(0, 5'd0, 5'd0, 5'd0, 0, 0);
      cyc();

      // lw r0 never stalls.
      inp = mkInstr(1, 5'd3, 5'd0, 5'd0, 1, 1);
      cyc();
      inp = mkInstr(1, 5'd0, 5'd0, 5'd13, 1, 0); usesRt = 1;
      #1 chk("r0_stall", {31'd0, Stall_ID}, 32'd0);
      cyc();
      chk("r0_valid", {31'd0, Valid_EX}, 32'd1);
      chk("r0_rd", {27'd0, RdAddr_EX}, 32'd13);

      // Invalid slot: fields captured, controls cleared.
      inp = mkInstr(0, 5'd2, 5'd3, 5'd7, 1, 1);
      cyc();
      chk("inv_rd", {27'd0, RdAddr_EX}, 32'd7);
      chk("inv_regw", {31'd0, RegWrite_EX}, 32'd0);
      chk("inv_memr", {31'd0, MemRead_EX}, 32'd0);

      // Mid-cycle reset with lw r8 in EX and a dependent instruction in ID.
      inp = mkInstr(1, 5'd9, 5'd8, 5'd8, 1, 1);
      cyc();
      inp = mkInstr(1, 5'd8, 5'd1, 5'd14, 1, 0);
      #1 chk("prerst_stall", {31'd0, Stall_ID}, 32'd1);
      rst_n = 0;
      #1;
      chk("rst_regs", {31'd0, dutEx != '0}, 32'd0);
      chk("rst_stall", {31'd0, Stall_ID}, 32'd0);
      cyc();
      rst_n = 1;

      // Randomized traffic biased toward load-use dependencies.
      for (int n = 0; n < 3000; n++) begin
         inp.valid    = ($urandom_range(0, 7) != 0);
         inp.rs       = ($urandom_range(0, 2) == 0) ? mdl.rd : 5'($urandom);
         inp.rt       = ($urandom_range(0, 2) == 0) ? mdl.rd : 5'($urandom);
         inp.rd       = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 4));
         inp.regWrite = 1'($urandom);
         inp.memRead  = ($urandom_range(0, 2) == 0);
         inp.memWrite = 1'($urandom);
         inp.memtoReg = 1'($urandom);
         inp.aluSrc   = 1'($urandom);
         inp.aluOp    = 4'($urandom);
         inp.rsData   = $urandom;
         inp.rtData   = $urandom;
         inp.imm      = $urandom;
         usesRt       = 1'($urandom);
         hold         = ($urandom_range(0, 7) == 0);
         flush        = ($urandom_range(0, 7) == 0);
         cyc();
      end
      hold = 0; flush = 0;
      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
